reorder_buffer_mc: RTL

- Parametrised in-order commit buffer for the Blimp out-of-order core.
- Generalises the single-entry-per-cycle writeback/commit path to N completion pipes and up to W in-order commits per cycle, with a configurable depth and a flush mode.
- Sits between the decode/issue stage, which allocates entries and receives sequence numbers, and the execute pipes, which report completion.
- Drives the commit notification used for instruction trace and physical-register freeing.

---
 rtl/rob_pkg.sv | 38 +++
 rtl/rob_commit_select.sv | 29 ++
 rtl/reorder_buffer_mc.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared types and pointer arithmetic for the multi-pipe reorder buffer.
// Pointers carry one wrap bit above the entry index.
package rob_pkg;

   localparam int unsigned ROB_SEQ_BITS_DEF = 5;
   localparam int unsigned ROB_DEPTH_DEF    = 1 << ROB_SEQ_BITS_DEF;
   localparam int unsigned ROB_PPREG_MAX    = 8;

   typedef struct packed {
      logic [31:0]              pc;
      logic [4:0]               waddr;
      logic                     wen;
      logic [ROB_PPREG_MAX-1:0] ppreg;
      logic [31:0]              wdata;
   } rob_entry_t;

   function automatic int unsigned rob_depth(input int unsigned seq_bits);
      return 32'd1 << seq_bits;
   endfunction

   // Pointer + n, wrapping modulo 2*depth.
   function automatic logic [31:0] ptr_add(input logic [31:0]  ptr,
                                           input logic [31:0]  n,
                                           input int unsigned  seq_bits);
      logic [31:0] wrap_mask;
      wrap_mask = (32'd1 << (seq_bits + 1)) - 32'd1;
      return (ptr + n) & wrap_mask;
   endfunction

   function automatic logic [31:0] ptr_dist(input logic [31:0]  ptr_a,
                                            input logic [31:0]  ptr_b,
                                            input int unsigned  seq_bits);
      logic [31:0] wrap_mask;
      wrap_mask = (32'd1 << (seq_bits + 1)) - 32'd1;
      return (ptr_a - ptr_b) & wrap_mask;
   endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Longest valid-and-done prefix starting at the head, wrapping modulo depth.
module rob_commit_select
   import rob_pkg::*;
#(
   parameter int unsigned p_seq_num_bits = 5,
   parameter int unsigned p_commit_width = 2
) (
   input  logic [p_seq_num_bits-1:0]      head_idx_i,
   input  logic [(1<<p_seq_num_bits)-1:0] valid_i,
   input  logic [(1<<p_seq_num_bits)-1:0] done_i,
   output logic [p_commit_width-1:0]      mask_o
);

   localparam int unsigned SB = p_seq_num_bits;

   always_comb begin
      logic          run;
      logic [SB-1:0] idx;
      run    = 1'b1;
      idx    = '0;
      mask_o = '0;
      for (int k = 0; k < p_commit_width; k++) begin
         idx       = head_idx_i + SB'(k);
         run       = run & valid_i[idx] & done_i[idx];
         mask_o[k] = run;
      end
   end

endmodule

// File: rtl/reorder_buffer_mc.sv
// In-order commit buffer: issue allocates at the tail, N pipes mark entries
// done, and up to W consecutive done entries retire from the head per cycle.
module reorder_buffer_mc
   import rob_pkg::*;
#(
   parameter int unsigned p_seq_num_bits   = 5,
   parameter int unsigned p_num_pipes      = 3,
   parameter int unsigned p_commit_width   = 2,
   parameter int unsigned p_phys_addr_bits = 6
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   alloc_val,
   output logic                                   alloc_rdy,
   output logic [p_seq_num_bits-1:0]              alloc_seq_num,
   input  logic [31:0]                            alloc_pc,
   input  logic [4:0]                             alloc_waddr,
   input  logic                                   alloc_wen,
   input  logic [p_phys_addr_bits-1:0]            alloc_ppreg,
   input  logic                                   flush,
   input  logic [p_num_pipes-1:0]                 cmpl_val,
   input  logic [p_num_pipes*p_seq_num_bits-1:0]  cmpl_seq_num,
   input  logic [p_num_pipes*32-1:0]              cmpl_wdata,
   output logic [p_commit_width-1:0]              commit_val,
   output logic [p_commit_width*32-1:0]           commit_pc,
   output logic [p_commit_width*5-1:0]            commit_waddr,
   output logic [p_commit_width*32-1:0]           commit_wdata,
   output logic [p_commit_width-1:0]              commit_wen,
   output logic [p_commit_width*p_phys_addr_bits-1:0] commit_ppreg,
   output logic [p_seq_num_bits:0]                occupancy
);

   localparam int unsigned SB  = p_seq_num_bits;
   localparam int unsigned PW  = SB + 1;
   localparam int unsigned D   = rob_depth(p_seq_num_bits);
   localparam int unsigned N   = p_num_pipes;
   localparam int unsigned W   = p_commit_width;
   localparam int unsigned PB  = p_phys_addr_bits;
   localparam int unsigned PPM = ROB_PPREG_MAX;

   logic [SB:0]   head_q, head_d;
   logic [SB:0]   tail_q, tail_d;
   logic [D-1:0]  valid_q, valid_d;
   logic [D-1:0]  done_q, done_d;
   rob_entry_t    ent_q [D];

   logic [SB-1:0] head_idx, tail_idx;
   logic          full;
   logic          alloc_fire;
   logic [W-1:0]  commit_mask;
   logic [31:0]   commit_cnt;
   logic [SB-1:0] slot_idx [W];
   logic [SB-1:0] cmpl_idx [N];

   assign head_idx   = head_q[SB-1:0];
   assign tail_idx   = tail_q[SB-1:0];
   assign full       = (head_idx == tail_idx) && (head_q[SB] != tail_q[SB]);
   assign alloc_rdy  = ~full;
   assign alloc_fire = alloc_val & ~full & ~flush;
   assign alloc_seq_num = tail_idx;

   always_comb begin
      occupancy = PW'(ptr_dist(32'(tail_q), 32'(head_q), SB));
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         cmpl_idx[i] = cmpl_seq_num[i*SB +: SB];
      end
   end

   always_comb begin
      for (int k = 0; k < W; k++) begin
         slot_idx[k] = head_idx + SB'(k);
      end
   end

   rob_commit_select #(
      .p_seq_num_bits (p_seq_num_bits),
      .p_commit_width (p_commit_width)
   ) u_commit_select (
      .head_idx_i (head_idx),
      .valid_i    (valid_q),
      .done_i     (done_q),
      .mask_o     (commit_mask)
   );

   always_comb begin
      commit_cnt = '0;
      for (int k = 0; k < W; k++) begin
         commit_cnt = commit_cnt + 32'(commit_mask[k]);
      end
   end

   // Completion is applied before commit clears so a retiring slot always ends empty.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      valid_d = valid_q;
      done_d  = done_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         valid_d = '0;
         done_d  = '0;
      end else begin
         if (alloc_fire) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            tail_d            = PW'(ptr_add(32'(tail_q), 32'd1, SB));
         end
         for (int i = 0; i < N; i++) begin
            if (cmpl_val[i]) begin
               done_d[cmpl_idx[i]] = 1'b1;
            end
         end
         for (int k = 0; k < W; k++) begin
            if (commit_mask[k]) begin
               valid_d[slot_idx[k]] = 1'b0;
               done_d[slot_idx[k]]  = 1'b0;
            end
         end
         head_d = PW'(ptr_add(32'(head_q), commit_cnt, SB));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= '0;
         done_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   // Payload needs no reset: valid/done gate every use of it.
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (alloc_fire) begin
            ent_q[tail_idx].pc    <= alloc_pc;
            ent_q[tail_idx].waddr <= alloc_waddr;
            ent_q[tail_idx].wen   <= alloc_wen;
            ent_q[tail_idx].ppreg <= PPM'(alloc_ppreg);
            ent_q[tail_idx].wdata <= '0;
         end
         for (int i = 0; i < N; i++) begin
            if (cmpl_val[i]) begin
               ent_q[cmpl_idx[i]].wdata <= cmpl_wdata[i*32 +: 32];
            end
         end
      end
   end

   always_comb begin
      commit_val   = '0;
      commit_pc    = '0;
      commit_waddr = '0;
      commit_wdata = '0;
      commit_wen   = '0;
      commit_ppreg = '0;
      for (int k = 0; k < W; k++) begin
         commit_val[k]             = commit_mask[k] & ~flush;
         commit_pc[k*32 +: 32]     = ent_q[slot_idx[k]].pc;
         commit_waddr[k*5 +: 5]    = ent_q[slot_idx[k]].waddr;
         commit_wdata[k*32 +: 32]  = ent_q[slot_idx[k]].wdata;
         commit_wen[k]             = ent_q[slot_idx[k]].wen;
         commit_ppreg[k*PB +: PB]  = ent_q[slot_idx[k]].ppreg[PB-1:0];
      end
   end

   logic unused_ppreg_hi;
   always_comb begin
      unused_ppreg_hi = 1'b0;
      for (int e = 0; e < D; e++) begin
         unused_ppreg_hi = unused_ppreg_hi ^ (^ent_q[e].ppreg);
      end
   end

   // Illegal completions: duplicate index in one cycle, or an idle entry.
   always @(posedge clk) begin
      if (rst && !flush) begin
         for (int i = 0; i < N; i++) begin
            if (cmpl_val[i]) begin
               assert (valid_q[cmpl_idx[i]]);
               for (int j = i + 1; j < N; j++) begin
                  assert (!(cmpl_val[j] && (cmpl_idx[j] == cmpl_idx[i])));
               end
            end
         end
      end
   end

endmodule
